// File: rtl/mmio_char_fifo.sv
// MMIO character port: decodes CPU stores into a char-data word and a control word,
// buffers characters in a first-word-fall-through FIFO and hands them to the typewriter.
module mmio_char_fifo #(
  parameter logic [31:0] CHAR_ADDR  = 32'h0000_FF00,
  parameter logic [31:0] CTRL_ADDR  = 32'h0000_FF04,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic                  clk_pix,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           write_data,
  output logic [7:0]            char_data,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  clear_screen
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  clear_reg, clear_next;

  logic char_hit, ctrl_hit;
  logic empty, full;
  logic pop, push_ok, flush;
  logic unused_bits;

  // Byte offset and the upper data bits carry no meaning for either register.
  assign unused_bits = ^{data_addr[1:0], write_data[31:8]};

  assign char_hit = mem_write && (data_addr[31:2] == CHAR_ADDR[31:2]);
  assign ctrl_hit = mem_write && (data_addr[31:2] == CTRL_ADDR[31:2]);

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign pop     = !empty && char_ready;
  // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign push_ok = char_hit && (!full || pop);
  assign flush   = ctrl_hit && write_data[0];

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    clear_next    = ctrl_hit && write_data[1];

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (char_hit && full && !pop) begin
      overflow_next = 1'b1;
    end
    if (ctrl_hit && write_data[2]) begin
      overflow_next = 1'b0;
    end

    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      clear_reg    <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      clear_reg    <= clear_next;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_pix) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= write_data[7:0];
    end
  end

  assign char_valid   = !empty;
  assign char_data    = empty ? 8'h00 : mem_reg[rd_ptr_reg];
  assign fifo_count   = count_reg;
  assign overflow     = overflow_reg;
  assign clear_screen = clear_reg;

endmodule
